// File: rtl/l2_instr_mem_responder_if.sv
// Shared instruction common bus as seen by the lower-level memory stub.
// Caches drive grant-qualified address; the responder drives data/strobe only while responding.
interface l2_instr_mem_responder_if #(
    parameter int ADDRESSSIZE = 32
);
    // Handshake: once Com_Bus_Gnt is seen high, the granted cache holds Address_Com from the
    // next edge; the responder answers with Data_in_Bus=1 and Data_Bus_Com valid, and holds
    // both until the edge at which Com_Bus_Gnt is seen low. There is no back-pressure.
    logic                   Com_Bus_Gnt;
    logic [ADDRESSSIZE-1:0] Address_Com;
    wire  [ADDRESSSIZE-1:0] Data_Bus_Com;
    wire                    Data_in_Bus;

    modport master (
        output Com_Bus_Gnt,
        output Address_Com,
        input  Data_Bus_Com,
        input  Data_in_Bus
    );

    modport slave (
        input  Com_Bus_Gnt,
        input  Address_Com,
        inout  Data_Bus_Com,
        inout  Data_in_Bus
    );
endinterface

// File: rtl/l2_instr_mem_responder.sv
// Instruction memory stub: captures a line address after grant, waits LATENCY cycles,
// then drives the stored word on the common bus until the grant drops.
module l2_instr_mem_responder #(
    parameter int ADDRESSSIZE   = 32,
    parameter int MEM_ADDR_BITS = 10,
    parameter int LATENCY       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    l2_instr_mem_responder_if.slave  bus,
    input  logic                     wr_en,
    input  logic [MEM_ADDR_BITS-1:0] wr_addr,
    input  logic [ADDRESSSIZE-1:0]   wr_data,
    output logic                     Busy,
    output logic [7:0]               Resp_count,
    output logic [1:0]               dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_DRIVE} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [MEM_ADDR_BITS-1:0] idx_q, idx_d;
    logic [ADDRESSSIZE-1:0]   data_q, data_d;
    logic [7:0]               resp_q, resp_d;
    logic                     busy_q, busy_d;
    logic                     drive_q, drive_d;
    logic [ADDRESSSIZE-1:0]   rd_word;
    logic                     unused_addr_bits;

    logic [ADDRESSSIZE-1:0] mem [2**MEM_ADDR_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Write-first: a backdoor write landing on the read edge is what gets returned.
    assign rd_word = (wr_en && (wr_addr == idx_q)) ? wr_data : mem[idx_q];

    assign unused_addr_bits = ^{bus.Address_Com[ADDRESSSIZE-1:MEM_ADDR_BITS+2], bus.Address_Com[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            resp_q  <= '0;
            busy_q  <= 1'b0;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
            busy_q  <= busy_d;
            drive_q <= drive_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        resp_d  = resp_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Com_Bus_Gnt) state_d = S_ARM;
            end
            S_ARM: begin
                if (bus.Com_Bus_Gnt) begin
                    idx_d   = bus.Address_Com[MEM_ADDR_BITS+1:2];
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!bus.Com_Bus_Gnt) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    data_d  = rd_word;
                    state_d = S_DRIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DRIVE: begin
                if (!bus.Com_Bus_Gnt) begin
                    resp_d  = resp_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        drive_d = (state_d == S_DRIVE);
    end

    assign bus.Data_Bus_Com = drive_q ? data_q : {ADDRESSSIZE{1'bz}};
    assign bus.Data_in_Bus  = drive_q ? 1'b1 : 1'bz;
    assign Busy             = busy_q;
    assign Resp_count       = resp_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_l2_instr_mem_responder.sv
// Bench for l2_instr_mem_responder: a LATENCY=4 and a LATENCY=1 instance share clock,
// reset and backdoor port; a shadow memory and per-instance response counters predict the bus.
module tb_l2_instr_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        busy4, busy1;
    logic [7:0]  resp4, resp1;
    logic [1:0]  st4, st1;

    l2_instr_mem_responder_if #(.ADDRESSSIZE(32)) bus4 ();
    l2_instr_mem_responder_if #(.ADDRESSSIZE(32)) bus1 ();

    l2_instr_mem_responder #(.ADDRESSSIZE(32), .MEM_ADDR_BITS(10), .LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .Busy(busy4), .Resp_count(resp4), .dbg_state(st4)
    );

    l2_instr_mem_responder #(.ADDRESSSIZE(32), .MEM_ADDR_BITS(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .Busy(busy1), .Resp_count(resp1), .dbg_state(st1)
    );

    always #5 clk = ~clk;

    // Reference model: memory contents, words owed on the bus, and completed responses.
    logic [31:0] shadow [1024];
    logic [31:0] exp_q[$];
    logic [7:0]  resp_exp [2];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs_busy(input int w);
        return (w == 0) ? 32'(busy4) : 32'(busy1);
    endfunction

    function automatic logic [31:0] obs_valid(input int w);
        return (w == 0) ? 32'(bus4.Data_in_Bus === 1'b1) : 32'(bus1.Data_in_Bus === 1'b1);
    endfunction

    function automatic logic [31:0] obs_data(input int w);
        return (w == 0) ? bus4.Data_Bus_Com : bus1.Data_Bus_Com;
    endfunction

    function automatic logic [31:0] obs_resp(input int w);
        return (w == 0) ? 32'(resp4) : 32'(resp1);
    endfunction

    task automatic set_gnt(input int w, input logic g);
        if (w == 0) bus4.Com_Bus_Gnt = g;
        else        bus1.Com_Bus_Gnt = g;
    endtask

    task automatic set_addr(input int w, input logic [31:0] a);
        if (w == 0) bus4.Address_Com = a;
        else        bus1.Address_Com = a;
    endtask

    task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        shadow[a] = d;
    endtask

    // race: 0 none, 1 write to the captured index on the DRIVE-entry edge, 2 one edge later.
    task automatic run_txn(input int w, input logic [31:0] addr, input int race,
                           input int hold_in, input bit rst_mid);
        int          lat;
        int          hold;
        logic [9:0]  idx;
        logic [31:0] nw;
        lat  = (w == 0) ? 4 : 1;
        hold = (race == 2 && hold_in == 0) ? 1 : hold_in;
        idx  = addr[11:2];
        nw   = $urandom;
        set_addr(w, addr);
        set_gnt(w, 1'b1);
        tick();
        check_eq("arm_busy", obs_busy(w), 32'd1);
        check_eq("arm_valid", obs_valid(w), 32'd0);
        tick();
        set_addr(w, $urandom);
        for (int k = 2; k <= lat + 1; k++) begin
            if (race == 1 && k == lat + 1) bd_write(idx, nw);
            else tick();
            if (k <= lat) check_eq("wait_valid", obs_valid(w), 32'd0);
        end
        exp_q.push_back(shadow[idx]);
        check_eq("drive_valid", obs_valid(w), 32'd1);
        check_eq("drive_data", obs_data(w), exp_q[0]);
        check_eq("drive_busy", obs_busy(w), 32'd1);
        for (int h = 0; h < hold; h++) begin
            if (race == 2 && h == 0) bd_write(idx, nw);
            else tick();
            check_eq("hold_valid", obs_valid(w), 32'd1);
            check_eq("hold_data", obs_data(w), exp_q[0]);
        end
        if (rst_mid) begin
            rst_n = 1'b0;
            tick();
            resp_exp[0] = '0;
            resp_exp[1] = '0;
            check_eq("rst_busy", obs_busy(w), 32'd0);
            check_eq("rst_valid", obs_valid(w), 32'd0);
            check_eq("rst_resp", obs_resp(w), 32'd0);
            check_eq("rst_resp_other", obs_resp(1 - w), 32'd0);
            rst_n = 1'b1;
            tick();
            check_eq("rst_rearm_busy", obs_busy(w), 32'd1);
            set_gnt(w, 1'b0);
            tick();
            check_eq("rst_idle_busy", obs_busy(w), 32'd0);
            check_eq("rst_idle_resp", obs_resp(w), 32'(resp_exp[w]));
        end else begin
            set_gnt(w, 1'b0);
            tick();
            resp_exp[w] = resp_exp[w] + 8'd1;
            check_eq("drop_busy", obs_busy(w), 32'd0);
            check_eq("drop_valid", obs_valid(w), 32'd0);
            check_eq("drop_resp", obs_resp(w), 32'(resp_exp[w]));
        end
        void'(exp_q.pop_front());
    endtask

    task automatic run_abort(input int w, input int n);
        set_addr(w, $urandom);
        set_gnt(w, 1'b1);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq("abort_valid", obs_valid(w), 32'd0);
        end
        set_gnt(w, 1'b0);
        tick();
        check_eq("abort_busy", obs_busy(w), 32'd0);
        check_eq("abort_valid_end", obs_valid(w), 32'd0);
        check_eq("abort_resp", obs_resp(w), 32'(resp_exp[w]));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int w;
        bus4.Com_Bus_Gnt = 1'b0;
        bus4.Address_Com = '0;
        bus1.Com_Bus_Gnt = 1'b0;
        bus1.Address_Com = '0;
        resp_exp[0] = '0;
        resp_exp[1] = '0;

        rst_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_busy", obs_busy(i), 32'd0);
            check_eq("reset_valid", obs_valid(i), 32'd0);
            check_eq("reset_resp", obs_resp(i), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 1024; i++) bd_write(10'(i), $urandom);
        bd_write(10'd5, 32'hDEADBEEF);

        run_txn(0, 32'h0000_0014, 0, 1, 1'b0);
        run_txn(0, 32'h0000_1014, 0, 0, 1'b0);
        run_abort(0, 3);
        run_txn(0, $urandom, 1, 1, 1'b0);
        run_txn(0, $urandom, 2, 2, 1'b0);
        run_txn(1, $urandom, 1, 0, 1'b0);
        run_txn(1, $urandom, 2, 1, 1'b0);
        run_abort(1, 2);

        for (int i = 0; i < 40; i++) begin
            w = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) bd_write(10'($urandom), $urandom);
            if ($urandom_range(0, 4) == 0) run_abort(w, $urandom_range(1, (w == 0) ? 5 : 2));
            else run_txn(w, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end

        run_txn(0, $urandom, 0, 2, 1'b1);

        for (int i = 0; i < 256; i++) run_txn(1, $urandom, 0, 0, 1'b0);
        check_eq("wrap_zero", obs_resp(1), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/l2_instr_mem_responder.md
# l2_instr_mem_responder

Lower-level instruction memory stub on the shared instruction common bus; it sits directly downstream of each per-core instruction cache block. When the arbiter grants the bus to a missing cache, it samples the line address the cache places on `Address_Com`. After a programmable latency it drives the stored word onto `Data_Bus_Com` and asserts `Data_in_Bus` until the grant is withdrawn. A synchronous backdoor write port lets the bench preload contents.

## Interface
- `ADDRESSSIZE`, 32: common-bus address/data width.
- `MEM_ADDR_BITS`, 10: word-index width; depth = 2^MEM_ADDR_BITS words.
- `LATENCY`, 4: cycles from address capture to data drive; legal range 1..15.
- `clk` in 1: single clock; all state changes on the posedge.
- `rst_n` in 1: reset, synchronous and active-low.
- `Com_Bus_Gnt` in 1: OR of all instruction-bus grants from the common arbiter.
- `Address_Com` inout `ADDRESSSIZE`: line address, driven by the granted cache; this block only reads it.
- `Data_Bus_Com` inout `ADDRESSSIZE`: response word; this block drives it in DRIVE, otherwise Z.
- `Data_in_Bus` inout 1: data-valid strobe; this block drives 1 in DRIVE, otherwise Z.
- `wr_en` in 1: backdoor write enable.
- `wr_addr` in `MEM_ADDR_BITS`: backdoor word index.
- `wr_data` in `ADDRESSSIZE`: backdoor write data.
- `Busy` out 1: high in ARM, WAIT and DRIVE.
- `Resp_count` out 8: count of completed responses; wraps.

## Operation
- Memory array: 2^MEM_ADDR_BITS x ADDRESSSIZE. Reset does not clear it.
- Word index = `Address_Com[MEM_ADDR_BITS+1:2]`. Bits [1:0] and bits above the index are ignored, so upper addresses alias.
- FSM states: IDLE, ARM, WAIT, DRIVE.
- IDLE: `Com_Bus_Gnt`=1 at an edge -> ARM. The cache drives the address only after it sees the grant, so the capture happens one cycle later.
- ARM:
  - `Com_Bus_Gnt`=1 -> latch the word index, load `cnt` = LATENCY-1, go to WAIT.
  - `Com_Bus_Gnt`=0 -> IDLE.
- WAIT:
  - `Com_Bus_Gnt`=0 -> IDLE (abort). `Resp_count` does not increment.
  - `cnt`==0 -> read memory at the latched index into `data_q`, go to DRIVE.
  - Otherwise `cnt` decrements.
- DRIVE:
  - `Data_Bus_Com` = `data_q`, `Data_in_Bus` = 1.
  - `Com_Bus_Gnt`=0 at an edge -> IDLE and `Resp_count` increments. Tri-state is released on that same edge.
- Backdoor write: `wr_en`=1 writes `wr_data` to `mem[wr_addr]` at the edge, in any state.
  - A write to the latched index at or before the WAIT->DRIVE edge is visible in `data_q`. The array read and the write occur on the same edge, and the write takes priority (write-first).
  - A write after DRIVE entry does not change `data_q`.
- Address changes while in WAIT or DRIVE are ignored. The index is latched only in ARM.
- `Resp_count` is 8-bit modulo: 255 + 1 -> 0.

## Timing
- Reset values while `rst_n`=0 at an edge:
  - state IDLE, `cnt` 0, `data_q` 0, `Busy` 0, `Resp_count` 0.
  - `Data_Bus_Com` Z, `Data_in_Bus` Z.
- Reset asserted mid-operation (ARM/WAIT/DRIVE) returns to IDLE at that edge. Buses are tri-stated from that edge. `Resp_count` is cleared.
- Latency: grant first seen at edge t -> ARM. Index captured at edge t+1. DRIVE entered at edge t+1+LATENCY. The cache samples `Data_in_Bus`=1 at edge t+2+LATENCY.
- Minimum DRIVE duration is one cycle. There is no upper bound; DRIVE holds while the grant holds.
- A grant drop and re-raise with at least one low edge between them gives two independent transactions. Grant continuously high after DRIVE keeps DRIVE; there is no auto-release.
- All outputs come from registers. `Busy` is asserted from the edge that enters ARM.

## Test plan
- Preload + single read: LATENCY=4. Write 0xDEADBEEF to index 5. Grant at edge 10, `Address_Com`=0x00000014 from edge 10. Required: `Data_in_Bus`=1 and `Data_Bus_Com`=0xDEADBEEF from edge 15. Drop the grant at edge 17. Required: Z at edge 17, `Resp_count`=1.
- Abort in WAIT: grant high for 3 edges only. Required: `Data_in_Bus` never 1, return to IDLE, `Resp_count` unchanged, `Busy` low after the drop edge.
- Write-first race: `wr_en` to the latched index with 0x12345678 on the WAIT->DRIVE edge. Required: `Data_Bus_Com`=0x12345678. The same write one edge later leaves the old data on the bus.
- Aliasing: `Address_Com`=0x00001014 with MEM_ADDR_BITS=10. Required: the word at index 5 is returned.
- Reset mid-DRIVE: `rst_n`=0 for one edge during DRIVE. Required: buses Z, `Busy`=0, `Resp_count`=0 from that edge, with the grant still high. The next grant edge after reset release restarts at ARM.
- Counter wrap and LATENCY=1: 256 back-to-back transactions, with DRIVE at edge t+2 in each. Required: `Resp_count` reads 0 after the 256th response.
